// File: rtl/ahb_resp_mux.sv
// AHB uncore response multiplexer: registers the data-phase region select and
// muxes read data, ready and response, forcing an error on unmapped or timed-out transfers.
module ahb_resp_mux #(
  parameter int XLEN    = 64,
  parameter int NREG    = 15,
  parameter int TIMEOUT = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [1:0]           HTRANS,
  input  logic                 HREADY,
  input  logic [NREG-1:0]      SelRegions,
  input  logic [NREG*XLEN-1:0] RegRDATA,
  input  logic [NREG-1:0]      RegREADYOUT,
  input  logic [NREG-1:0]      RegRESP,
  output logic [XLEN-1:0]      HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [NREG-1:0]      SelD,
  output logic                 TimeoutErr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  logic             accept;
  logic [NREG-1:0]  sel_next;
  state_t           accept_state;
  logic [XLEN-1:0]  reg_rdata;
  logic             reg_ready;
  logic             reg_resp;
  logic             timeout_hit;
  logic             unused;

  assign unused = HTRANS[0];

  // Lowest-index region among bits NREG-1..1 wins; nothing decoded maps to bit 0.
  function automatic logic [NREG-1:0] reduce_sel(input logic [NREG-1:0] sel);
    logic [NREG-1:0] r;
    r = NREG'(1);
    for (int k = NREG - 1; k >= 1; k--) begin
      if (sel[k]) r = NREG'(1) << k;
    end
    return r;
  endfunction

  assign accept       = HSEL & HTRANS[1] & HREADY;
  assign sel_next     = reduce_sel(SelRegions);
  assign accept_state = sel_next[0] ? ERR1 : DATA;

  always_comb begin
    reg_rdata = '0;
    for (int k = 0; k < NREG; k++) begin
      if (SelD[k]) reg_rdata = reg_rdata | RegRDATA[k*XLEN +: XLEN];
    end
  end

  assign reg_ready   = |(SelD & RegREADYOUT);
  assign reg_resp    = |(SelD & RegRESP);
  assign timeout_hit = (state == DATA) && !reg_ready && (wait_cnt == CNT_MAX);

  // Outputs depend only on registered state, SelD and the region inputs.
  always_comb begin
    HRDATA    = '0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      DATA: begin
        if (timeout_hit) begin
          HREADYOUT = 1'b0;
          HRESP     = 1'b1;
        end else begin
          HRDATA    = reg_rdata;
          HREADYOUT = reg_ready;
          HRESP     = reg_resp;
        end
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      SelD       <= '0;
      wait_cnt   <= '0;
      TimeoutErr <= 1'b0;
    end else begin
      if (accept) SelD <= sel_next;
      else if (HREADY) SelD <= '0;

      case (state)
        IDLE, ERR2: begin
          if (accept) begin
            state    <= accept_state;
            wait_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (reg_ready) begin
            if (accept) begin
              state    <= accept_state;
              wait_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (timeout_hit) begin
            // Region is abandoned; ERR2 ignores any late ready it may still raise.
            state      <= ERR2;
            TimeoutErr <= 1'b1;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR1: state <= ERR2;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Bench for ahb_resp_mux: vector table plus hand sequences, checked through a
// scoreboard queue that the data-phase monitor drains on each completed transfer.
module tb_ahb_resp_mux;
  localparam int XLEN    = 32;
  localparam int NREG    = 15;
  localparam int TIMEOUT = 4;

  logic                 hclk = 1'b0;
  logic                 hresetn;
  logic                 hsel;
  logic [1:0]           htrans;
  wire                  hready;
  logic [NREG-1:0]      sel_regions;
  logic [NREG*XLEN-1:0] reg_rdata;
  logic [NREG-1:0]      reg_readyout;
  logic [NREG-1:0]      reg_resp;
  logic [XLEN-1:0]      hrdata;
  logic                 hreadyout;
  logic                 hresp;
  logic [NREG-1:0]      sel_d;
  logic                 timeout_err;

  assign hready = hreadyout;

  ahb_resp_mux #(.XLEN(XLEN), .NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HTRANS(htrans), .HREADY(hready),
    .SelRegions(sel_regions), .RegRDATA(reg_rdata), .RegREADYOUT(reg_readyout),
    .RegRESP(reg_resp), .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .SelD(sel_d), .TimeoutErr(timeout_err)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [NREG-1:0] sel;
    logic [XLEN-1:0] dat;
    int              w;
    logic            regresp;
    logic [NREG-1:0] seld;
    logic [XLEN-1:0] rdata;
    logic            resp;
    int              low;
  } vec_t;

  typedef struct {
    logic [NREG-1:0] seld;
    logic [XLEN-1:0] rdata;
    logic            resp;
    int              low;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_pass = 0;
  int   n_total = 0;
  bit   dphase = 1'b0;
  bit   first = 1'b0;
  int   low_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_data(input logic [XLEN-1:0] dat);
    for (int j = 0; j < NREG; j++) reg_rdata[j*XLEN +: XLEN] = dat + XLEN'(j);
  endtask

  task automatic push(input logic [NREG-1:0] seld, input logic [XLEN-1:0] rdata,
                      input logic resp, input int low);
    exp_t e;
    e.seld = seld; e.rdata = rdata; e.resp = resp; e.low = low;
    sb.push_back(e);
  endtask

  task automatic addr(input logic [NREG-1:0] sel, input logic [1:0] tr);
    hsel = 1'b1; htrans = tr; sel_regions = sel;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00; sel_regions = '0;
  endtask

  // Data-phase monitor: completes a transfer on the first cycle HREADY is high.
  always @(negedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dphase  = 1'b0;
      first   = 1'b0;
      low_cnt = 0;
    end else begin
      if (dphase) begin
        if (first) begin
          if (sb.size() > 0) check("sb_seld", 64'(sel_d), 64'(sb[0].seld));
          first = 1'b0;
        end
        if (hready) begin
          if (sb.size() == 0) begin
            check("sb_empty", 64'(sb.size()), 64'd1);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_rdata", 64'(hrdata), 64'(e.rdata));
            check("sb_resp", 64'(hresp), 64'(e.resp));
            check("sb_wait_cycles", 64'(low_cnt), 64'(e.low));
          end
          dphase = 1'b0;
        end else begin
          low_cnt++;
        end
      end
      if (hready && hsel && htrans[1]) begin
        dphase = 1'b1; first = 1'b1; low_cnt = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input logic [1:0] tr);
    int n;
    @(posedge hclk); #1;
    addr(v.sel, tr);
    set_data(v.dat);
    reg_resp = v.regresp ? '1 : '0;
    reg_readyout = '1;
    push(v.seld, v.rdata, v.resp, v.low);
    @(posedge hclk); #1;
    idle_bus();
    n = 0;
    reg_readyout = (v.w == 0) ? '1 : '0;
    while (dphase && n < 40) begin
      @(posedge hclk); #1;
      n++;
      if (n >= v.w) reg_readyout = '1;
    end
    if (dphase) check("vec_hang", 64'(n), 64'd0);
    reg_readyout = '1;
    reg_resp = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            sel      dat            w  rr    seld     rdata          resp low
    vecs[0] = '{15'h0100, 32'h0000_009D, 0, 1'b0, 15'h0100, 32'h0000_00A5, 1'b0, 0};
    vecs[1] = '{15'h0001, 32'h0000_0011, 0, 1'b0, 15'h0001, 32'h0000_0000, 1'b1, 1};
    vecs[2] = '{15'h0A00, 32'h0000_1000, 2, 1'b0, 15'h0200, 32'h0000_1009, 1'b0, 2};
    vecs[3] = '{15'h0040, 32'h0000_0033, 10, 1'b0, 15'h0040, 32'h0000_0000, 1'b1, 5};
    vecs[4] = '{15'h4000, 32'hFFFF_FFF0, 3, 1'b0, 15'h4000, 32'hFFFF_FFFE, 1'b0, 3};
    vecs[5] = '{15'h0003, 32'h0000_0020, 0, 1'b0, 15'h0002, 32'h0000_0021, 1'b0, 0};
    vecs[6] = '{15'h0002, 32'h0000_0050, 4, 1'b0, 15'h0002, 32'h0000_0051, 1'b0, 4};
    vecs[7] = '{15'h0000, 32'h0000_0044, 0, 1'b0, 15'h0001, 32'h0000_0000, 1'b1, 1};
    vecs[8] = '{15'h0010, 32'h0000_0300, 1, 1'b1, 15'h0010, 32'h0000_0304, 1'b1, 1};

    hresetn = 1'b0;
    idle_bus();
    reg_readyout = '1;
    reg_resp = '1;
    set_data(32'h1234_0000);
    #1;
    check("rst_hreadyout", 64'(hreadyout), 64'd1);
    check("rst_hresp", 64'(hresp), 64'd0);
    check("rst_hrdata", 64'(hrdata), 64'd0);
    check("rst_seld", 64'(sel_d), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    reg_resp = '0;

    // BUSY transfer type must not be accepted
    @(posedge hclk); #1;
    addr(15'h0100, 2'b01);
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    check("busy_seld", 64'(sel_d), 64'd0);
    check("busy_hresp", 64'(hresp), 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], (i % 2 == 0) ? 2'b10 : 2'b11);
      if (i == 2) check("timeout_err_before", 64'(timeout_err), 64'd0);
    end
    check("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // Unmapped access, cycle by cycle
    @(posedge hclk); #1;
    addr(15'h0001, 2'b10);
    push(15'h0001, '0, 1'b1, 1);
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    check("unmap_c1_rdy", 64'(hreadyout), 64'd0);
    check("unmap_c1_resp", 64'(hresp), 64'd1);
    @(negedge hclk);
    check("unmap_c2_rdy", 64'(hreadyout), 64'd1);
    check("unmap_c2_resp", 64'(hresp), 64'd1);
    @(negedge hclk);
    check("unmap_c3_rdy", 64'(hreadyout), 64'd1);
    check("unmap_c3_resp", 64'(hresp), 64'd0);

    // Timeout on region 6 followed by a late ready that must be ignored
    @(posedge hclk); #1;
    addr(15'h0040, 2'b10);
    set_data(32'h0000_0077);
    push(15'h0040, '0, 1'b1, 5);
    @(posedge hclk); #1;
    idle_bus();
    reg_readyout = '0;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge hclk);
      check("to_wait_rdy", 64'(hreadyout), 64'd0);
      check("to_wait_resp", 64'(hresp), 64'd0);
    end
    @(negedge hclk);
    check("to_fire_rdy", 64'(hreadyout), 64'd0);
    check("to_fire_resp", 64'(hresp), 64'd1);
    @(posedge hclk); #1;
    reg_readyout = '1;
    @(negedge hclk);
    check("to_late_rdy", 64'(hreadyout), 64'd1);
    check("to_late_resp", 64'(hresp), 64'd1);
    check("to_late_rdata", 64'(hrdata), 64'd0);

    // Back-to-back: region 5 completes while region 9 is accepted
    @(posedge hclk); #1;
    set_data(32'h0000_0500);
    addr(15'h0020, 2'b10);
    push(15'h0020, 32'h0000_0505, 1'b0, 1);
    @(posedge hclk); #1;
    idle_bus();
    reg_readyout = '0;
    @(negedge hclk);
    check("b2b_wait_rdy", 64'(hreadyout), 64'd0);
    @(posedge hclk); #1;
    reg_readyout = '1;
    addr(15'h0200, 2'b10);
    push(15'h0200, 32'h0000_0509, 1'b0, 0);
    @(negedge hclk);
    check("b2b_first_seld", 64'(sel_d), 64'h0020);
    check("b2b_first_rdy", 64'(hreadyout), 64'd1);
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    check("b2b_no_gap_seld", 64'(sel_d), 64'h0200);
    check("b2b_no_gap_rdata", 64'(hrdata), 64'h0509);

    // Reset pulsed during ERR1, then first acceptance right after release
    @(posedge hclk); #1;
    addr(15'h0001, 2'b10);
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    check("abort_err1_rdy", 64'(hreadyout), 64'd0);
    #2 hresetn = 1'b0;
    #1;
    check("abort_rdy", 64'(hreadyout), 64'd1);
    check("abort_resp", 64'(hresp), 64'd0);
    check("abort_seld", 64'(sel_d), 64'd0);
    check("abort_timeout_err", 64'(timeout_err), 64'd0);
    @(posedge hclk); #2;
    hresetn = 1'b1;
    set_data(32'h0000_009D);
    addr(15'h0100, 2'b10);
    push(15'h0100, 32'h0000_00A5, 1'b0, 0);
    @(negedge hclk);
    check("abort_no_err2_resp", 64'(hresp), 64'd0);
    check("abort_no_err2_rdy", 64'(hreadyout), 64'd1);
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    check("post_rst_rdata", 64'(hrdata), 64'h00A5);
    repeat (2) @(posedge hclk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
